// File: rtl/ofs_plat_avalon_mem_arb2.sv
// ofs_plat_avalon_mem_arb2
// Two-master to one-slave Avalon-MM arbiter, zero-cycle command latency.
// Round-robin grant in ARB; grant is locked to the owner for the rest of a
// write burst. A read-tracking FIFO of {master id, burstcount} steers read
// responses back to the master that issued the read.
// Optional build macro OFS_PLAT_AVALON_MEM_ARB_STATS_EN adds the per-master
// accepted-request counters gnt_cnt_0 / gnt_cnt_1.

module ofs_plat_avalon_mem_arb2 #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int RD_FIFO_DEPTH   = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,

   // master 0
   input  logic [ADDR_WIDTH-1:0]      m0_address,
   input  logic                       m0_read,
   input  logic                       m0_write,
   input  logic [BURST_CNT_WIDTH-1:0] m0_burstcount,
   input  logic [DATA_WIDTH-1:0]      m0_writedata,
   input  logic [DATA_WIDTH/8-1:0]    m0_byteenable,
   output logic                       m0_waitrequest,
   output logic                       m0_readdatavalid,
   output logic [DATA_WIDTH-1:0]      m0_readdata,
   output logic [1:0]                 m0_response,

   // master 1
   input  logic [ADDR_WIDTH-1:0]      m1_address,
   input  logic                       m1_read,
   input  logic                       m1_write,
   input  logic [BURST_CNT_WIDTH-1:0] m1_burstcount,
   input  logic [DATA_WIDTH-1:0]      m1_writedata,
   input  logic [DATA_WIDTH/8-1:0]    m1_byteenable,
   output logic                       m1_waitrequest,
   output logic                       m1_readdatavalid,
   output logic [DATA_WIDTH-1:0]      m1_readdata,
   output logic [1:0]                 m1_response,

   // slave
   output logic [ADDR_WIDTH-1:0]      s_address,
   output logic                       s_read,
   output logic                       s_write,
   output logic [BURST_CNT_WIDTH-1:0] s_burstcount,
   output logic [DATA_WIDTH-1:0]      s_writedata,
   output logic [DATA_WIDTH/8-1:0]    s_byteenable,
   input  logic                       s_waitrequest,
   input  logic                       s_readdatavalid,
   input  logic [DATA_WIDTH-1:0]      s_readdata,
   input  logic [1:0]                 s_response
`ifdef OFS_PLAT_AVALON_MEM_ARB_STATS_EN
   ,
   output logic [31:0]                gnt_cnt_0,
   output logic [31:0]                gnt_cnt_1
`endif
);

   localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE = BURST_CNT_WIDTH'(1);

   typedef enum logic {ST_ARB, ST_WR_BURST} state_t;

   typedef struct packed {
      logic                       id;
      logic [BURST_CNT_WIDTH-1:0] burstcount;
   } rd_entry_t;

   state_t                     r_state;
   logic                       r_last_gnt;
   logic                       r_owner;
   logic [BURST_CNT_WIDTH-1:0] r_wr_remaining;

   rd_entry_t                  r_fifo [RD_FIFO_DEPTH];
   logic [PTR_W-1:0]           r_wr_ptr;
   logic [PTR_W-1:0]           r_rd_ptr;
   logic [CNT_W-1:0]           r_cnt;
   logic [BURST_CNT_WIDTH-1:0] r_rd_beats;

   logic      w_arb;
   logic      w_req0;
   logic      w_req1;
   logic      w_gnt_valid;
   logic      w_gnt;
   logic      w_sel_read;
   logic      w_sel_write;
   logic      w_rd_cmd;
   logic      w_rd_full;
   logic      w_accept;
   logic      w_push;
   logic      w_pop;
   logic      w_rsp_valid;
   logic      w_rd_last;
   rd_entry_t w_head;

   // A new request is only seen in ARB; burstcount 0 is never forwarded.
   assign w_arb  = (r_state == ST_ARB);
   assign w_req0 = w_arb & (m0_read | m0_write) & (m0_burstcount != '0);
   assign w_req1 = w_arb & (m1_read | m1_write) & (m1_burstcount != '0);

   // Grant selection: locked owner during a write burst, round-robin otherwise.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
      w_gnt_valid = 1'b0;
      w_gnt       = 1'b0;
      if (reset_n) begin
         if (!w_arb) begin
            w_gnt_valid = 1'b1;
            w_gnt       = r_owner;
         end else if (w_req0 && w_req1) begin
            w_gnt_valid = 1'b1;
            w_gnt       = ~r_last_gnt;
         end else if (w_req0) begin
            w_gnt_valid = 1'b1;
            w_gnt       = 1'b0;
         end else if (w_req1) begin
            w_gnt_valid = 1'b1;
            w_gnt       = 1'b1;
         end
      end
   end

   // Command mux toward the slave.
   assign w_sel_read   = w_gnt ? m1_read  : m0_read;
   assign w_sel_write  = w_gnt ? m1_write : m0_write;
   assign s_address    = w_gnt ? m1_address    : m0_address;
   assign s_burstcount = w_gnt ? m1_burstcount : m0_burstcount;
   assign s_writedata  = w_gnt ? m1_writedata  : m0_writedata;
   assign s_byteenable = w_gnt ? m1_byteenable : m0_byteenable;

   // Full comes from the registered count, so a same-cycle pop never frees a slot early.
   assign w_rd_full = (r_cnt == CNT_W'(RD_FIFO_DEPTH));
   assign w_rd_cmd  = w_gnt_valid & w_arb & w_sel_read;
   assign s_read    = w_rd_cmd & ~w_rd_full;
   assign s_write   = w_gnt_valid & w_sel_write & ~(w_arb & w_sel_read);
   assign w_accept  = (s_read | s_write) & ~s_waitrequest;
   assign w_push    = s_read & ~s_waitrequest;

   assign m0_waitrequest = ~(w_gnt_valid & ~w_gnt & ~s_waitrequest & ~(w_rd_cmd & w_rd_full));
   assign m1_waitrequest = ~(w_gnt_valid &  w_gnt & ~s_waitrequest & ~(w_rd_cmd & w_rd_full));

   // Response steering from the FIFO head.
   assign w_head      = r_fifo[r_rd_ptr];
   assign w_rsp_valid = s_readdatavalid & (r_cnt != '0);
   assign w_rd_last   = (r_rd_beats == (w_head.burstcount - BC_ONE));
   assign w_pop       = w_rsp_valid & w_rd_last;

   assign m0_readdatavalid = w_rsp_valid & ~w_head.id;
   assign m1_readdatavalid = w_rsp_valid &  w_head.id;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_response      = s_response;
   assign m1_response      = s_response;

   // Arbitration FSM: tracks last grant and write-burst ownership.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         r_state        <= ST_ARB;
         r_last_gnt     <= 1'b1;
         r_owner        <= 1'b0;
         r_wr_remaining <= '0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_accept) begin
                  r_last_gnt <= w_gnt;
                  if (s_write && (s_burstcount > BC_ONE)) begin
                     r_state        <= ST_WR_BURST;
                     r_owner        <= w_gnt;
                     r_wr_remaining <= s_burstcount - BC_ONE;
                  end
               end
            end
            ST_WR_BURST: begin
               if (w_accept) begin
                  if (r_wr_remaining == BC_ONE) r_state <= ST_ARB;
                  r_wr_remaining <= r_wr_remaining - BC_ONE;
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

   // Read-tracking FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; pointers and count alone decide which entries are live.
      if (w_push) r_fifo[r_wr_ptr] <= '{id: w_gnt, burstcount: s_burstcount};
   end

   // FIFO pointers, occupancy and head-burst beat counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_rd_beats <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_rsp_valid) r_rd_beats <= w_rd_last ? '0 : (r_rd_beats + BC_ONE);
      end
   end

`ifdef OFS_PLAT_AVALON_MEM_ARB_STATS_EN
   logic [31:0] r_gnt_cnt_0;
   logic [31:0] r_gnt_cnt_1;

   // Saturating count of requests accepted per master (reads and write SOPs).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gnt_cnt_0 <= '0;
         r_gnt_cnt_1 <= '0;
      end else if (w_accept && w_arb) begin
         if (!w_gnt && (r_gnt_cnt_0 != '1)) r_gnt_cnt_0 <= r_gnt_cnt_0 + 32'd1;
         if ( w_gnt && (r_gnt_cnt_1 != '1)) r_gnt_cnt_1 <= r_gnt_cnt_1 + 32'd1;
      end
   end

   assign gnt_cnt_0 = r_gnt_cnt_0;
   assign gnt_cnt_1 = r_gnt_cnt_1;
`endif

   // A request carrying burstcount 0 is a master bug.
   a_m0_bc_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
      (w_arb && (m0_read || m0_write)) |-> (m0_burstcount != '0))
      else $fatal(1, "m0 request with burstcount 0");
   a_m1_bc_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
      (w_arb && (m1_read || m1_write)) |-> (m1_burstcount != '0))
      else $fatal(1, "m1 request with burstcount 0");

endmodule

// File: doc/ofs_plat_avalon_mem_arb2.md
OFS_PLAT_AVALON_MEM_ARB2 -- requirements
Module: ofs_plat_avalon_mem_arb2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of both masters and the slave.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: read and write data width.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 7: burstcount width.
REQ-004 SHALL have parameter RD_FIFO_DEPTH, default 32 (power of 2): number of outstanding read bursts tracked.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on posedge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports mN_address/mN_read/mN_write/mN_burstcount/mN_writedata/mN_byteenable (N=0,1), input, ADDR_WIDTH/1/1/BURST_CNT_WIDTH/DATA_WIDTH/DATA_WIDTH/8: master commands.
REQ-008 SHALL have ports mN_waitrequest/mN_readdatavalid/mN_readdata/mN_response, output, 1/1/DATA_WIDTH/2: master responses.
REQ-009 SHALL have ports s_address/s_read/s_write/s_burstcount/s_writedata/s_byteenable, output, widths as REQ-007: slave command.
REQ-010 SHALL have ports s_waitrequest/s_readdatavalid/s_readdata/s_response, input, 1/1/DATA_WIDTH/2: slave response; WAIT_REQUEST_ALLOWANCE is 0 on all sides.

Function
REQ-011 SHALL arbitrate one slave between two masters; a request is mN_read or (mN_write at write SOP).
REQ-012 SHALL have FSM states ARB and WR_BURST; ARB -> WR_BURST when a write with burstcount>1 is accepted; WR_BURST -> ARB when the final beat is accepted.
REQ-013 In ARB, SHALL grant round-robin: with both requesting, grant the master not granted last; with one requesting, grant it.
REQ-014 In WR_BURST, SHALL lock the grant to the owning master; the other master's requests are held off.
REQ-015 SHALL drive the granted master's command to the slave combinationally, giving zero-cycle command latency.
REQ-016 SHALL deassert s_read and s_write when no master is granted.
REQ-017 SHALL define a beat as accepted when s_read or s_write is asserted and s_waitrequest=0.
REQ-018 SHALL drive mN_waitrequest=0 only for the granted master when s_waitrequest=0 and (not a read, or the read FIFO is not full); otherwise mN_waitrequest=1.
REQ-019 On each accepted read, SHALL push {master id, burstcount} into the read FIFO; with the FIFO full, SHALL suppress s_read and stall that master.
REQ-020 SHALL route s_readdatavalid/s_readdata/s_response to the master at the FIFO head and count beats down; pop on the last beat.
REQ-021 Same-cycle push and pop with the FIFO full SHALL be permitted only when pop precedes push (full flag from registered count); no beat SHALL be lost.
REQ-022 SHALL hold mN_readdatavalid=0 for the non-owner; readdata/response MAY pass through to both.
REQ-023 SHALL treat burstcount 0 on a request as an error (simulation $fatal) and never issue it to the slave.
REQ-024 SHALL track the write beat counter at BURST_CNT_WIDTH bits; the last beat is when remaining==1.
REQ-025 SHALL tolerate a master holding a request across mN_waitrequest=1 without changing it; a changed command before acceptance is a protocol error.

Reset
REQ-026 On reset_n=0, asynchronously: FSM=ARB, last-grant=master 1 (so master 0 wins first), FIFO empty, beat counters 0.
REQ-027 During reset: s_read=0, s_write=0, mN_readdatavalid=0, mN_waitrequest=1.
REQ-028 Reset mid-burst SHALL abandon all in-flight state; no response is routed after reset deasserts until a new read is accepted.

Configuration
REQ-029 With macro OFS_PLAT_AVALON_MEM_ARB_STATS_EN defined, SHALL add outputs gnt_cnt_0 and gnt_cnt_1 (32 bits each), counting accepted requests per master, saturating at 2^32-1, reset to 0.
REQ-030 Without OFS_PLAT_AVALON_MEM_ARB_STATS_EN, those ports and counters SHALL be absent, with identical arbitration behaviour.

Verification
REQ-031 Both masters issue single-beat reads continuously, s_waitrequest=0 -> grants alternate 0,1,0,1; each master receives only its own data, in order.
REQ-032 m0 writes burstcount=4 while m1 reads -> four m0 beats back-to-back; m1 read issues on the cycle after the 4th beat.
REQ-033 m0 issues 32 reads of burstcount=2 with the slave not responding -> 33rd read stalled (m0_waitrequest=1); it is accepted in the cycle after the first burst's final response beat.
REQ-034 s_waitrequest=1 for 5 cycles mid write burst -> grant stays on the owner; the beat count resumes correctly and no beats are duplicated.
REQ-035 reset_n pulsed low during a burstcount=8 read response -> outputs take reset values immediately; the next read returns correctly routed data.
REQ-036 With STATS_EN, 10 m0 and 7 m1 accepted requests -> gnt_cnt_0=10, gnt_cnt_1=7.
